// File: rtl/wbc_waitmem.sv
// wbc_waitmem: Wishbone B3 classic RAM slave with a fixed number of wait states
module wbc_waitmem #(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int LGMEMSZ = 10,
    parameter int WAITS   = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_cyc,
    input  logic            i_stb,
    input  logic            i_we,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_data,
    input  logic [DW/8-1:0] i_sel,
    input  logic [2:0]      i_cti,
    input  logic [1:0]      i_bte,
    output logic            o_ack,
    output logic [DW-1:0]   o_data,
    output logic            o_err
);
    localparam int CW = (WAITS > 0) ? $clog2(WAITS + 1) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t             state;
    logic [CW-1:0]      cnt;
    logic               bad_q;
    logic [DW-1:0]      mem [0:(1<<LGMEMSZ)-1];
    logic [LGMEMSZ-1:0] idx;
    logic [AW:0]        addr_ext;
    logic               req, bad_now, bad, fire, unused_bte;
    assign unused_bte = ^i_bte;
    assign idx      = i_addr[LGMEMSZ-1:0];
    assign addr_ext = {1'b0, i_addr};
    assign req      = i_cyc && i_stb;
    assign bad_now  = ((addr_ext >> LGMEMSZ) != '0) || (i_cti >= 3'd3 && i_cti <= 3'd6);
    assign bad      = (state == IDLE) ? bad_now : bad_q;
    assign fire     = req && !i_reset && ((state == IDLE && WAITS == 0) || (state == WAIT && cnt == CW'(1)));
    // Control FSM: count wait states, then raise a one-cycle ack/err and capture read data
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bad_q  <= 1'b0;
            o_ack  <= 1'b0;
            o_err  <= 1'b0;
            o_data <= '0;
        end else begin
            o_ack <= fire && !bad;
            o_err <= fire && bad;
            if (fire && !bad && !i_we)
                o_data <= mem[idx];
            case (state)
                IDLE: if (req) begin
                    cnt   <= CW'(WAITS);
                    bad_q <= bad_now;
                    state <= (WAITS > 0) ? WAIT : RESP;
                end
                WAIT: begin
                    cnt   <= cnt - CW'(1);
                    state <= !req ? IDLE : (fire ? RESP : WAIT);
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Byte-masked write, committed on the edge that raises o_ack
    always_ff @(posedge i_clk) begin
        if (fire && !bad && i_we)
            for (int b = 0; b < DW/8; b++)
                if (i_sel[b])
                    mem[idx][8*b +: 8] <= i_data[8*b +: 8];
    end
endmodule

// File: tb/tb_wbc_waitmem.sv
// tb_wbc_waitmem: randomized and directed checks of wbc_waitmem against a behavioural model
module tb_wbc_waitmem;
    logic        i_clk, i_reset, i_stb, i_we;
    logic [1:0]  cyc, ack, err;
    logic [11:0] i_addr;
    logic [31:0] i_data;
    logic [3:0]  i_sel;
    logic [2:0]  i_cti;
    logic [31:0] rdata [2];
    logic [31:0] ref_mem [2][1024];
    bit          valid [2][1024];
    int          total = 0, bad = 0;

    wbc_waitmem #(.AW(12), .DW(32), .LGMEMSZ(10), .WAITS(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cyc(cyc[0]), .i_stb(i_stb), .i_we(i_we),
        .i_addr(i_addr), .i_data(i_data), .i_sel(i_sel), .i_cti(i_cti), .i_bte(2'b00),
        .o_ack(ack[0]), .o_data(rdata[0]), .o_err(err[0]));

    wbc_waitmem #(.AW(12), .DW(32), .LGMEMSZ(10), .WAITS(0)) dut0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_cyc(cyc[1]), .i_stb(i_stb), .i_we(i_we),
        .i_addr(i_addr), .i_data(i_data), .i_sel(i_sel), .i_cti(i_cti), .i_bte(2'b01),
        .o_ack(ack[1]), .o_data(rdata[1]), .o_err(err[1]));

    initial i_clk = 0;
    always #5 i_clk = ~i_clk;

    function automatic int waits_of(input int w);
        return (w == 0) ? 2 : 0;
    endfunction

    // Reference: returns whether the transfer must error, and applies a legal write
    function automatic logic model(input int w, input logic we, input logic [11:0] a,
                                   input logic [31:0] d, input logic [3:0] s, input logic [2:0] c);
        logic e;
        e = (a >= 12'd1024) || (c >= 3'd3 && c <= 3'd6);
        if (!e && we) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[w][a[9:0]][8*b +: 8] = d[8*b +: 8];
            if (s == 4'hF) valid[w][a[9:0]] = 1;
        end
        return e;
    endfunction

    // One classic transfer; observes 10 cycles, optionally dropping i_cyc after cycle abort_at
    task automatic xfer(input int w, input logic we, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] c, input int abort_at,
                        output int at, output logic got_err, output int pulses, output logic [31:0] rd);
        at = -1; got_err = 0; pulses = 0; rd = 0;
        i_we = we; i_addr = a; i_data = d; i_sel = s; i_cti = c; i_stb = 1; cyc[w] = 1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge i_clk); #1;
            pulses += int'(ack[w]) + int'(err[w]);
            if ((ack[w] || err[w]) && at < 0) begin
                at = k; got_err = err[w]; rd = rdata[w]; cyc[w] = 0; i_stb = 0;
            end
            if (k == abort_at) cyc[w] = 0;
        end
        cyc[w] = 0; i_stb = 0;
    endtask

    task automatic test_reset;
        i_reset = 1; cyc = 0; i_stb = 0; i_we = 0; i_addr = 0; i_data = 0; i_sel = 0; i_cti = 0;
        repeat (3) @(posedge i_clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            total++; if (ack[w] !== 1'b0) begin bad++; $display("FAIL reset_ack[%0d]: got %b want 0", w, ack[w]); end
            total++; if (err[w] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", w, err[w]); end
            total++; if (rdata[w] !== 32'h0) begin bad++; $display("FAIL reset_data[%0d]: got %h want 0", w, rdata[w]); end
        end
        i_reset = 0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_basic;
        int at, p; logic e; logic [31:0] rd;
        void'(model(0, 1, 12'd5, 32'hDEADBEEF, 4'hF, 3'b000));
        xfer(0, 1, 12'd5, 32'hDEADBEEF, 4'hF, 3'b000, 0, at, e, p, rd);
        total++; if (at != 3 || e !== 1'b0 || p != 1) begin bad++; $display("FAIL basic_write: at=%0d err=%b pulses=%0d want 3/0/1", at, e, p); end
        xfer(0, 0, 12'd5, 32'h0, 4'hF, 3'b000, 0, at, e, p, rd);
        total++; if (at != 3 || e !== 1'b0 || p != 1) begin bad++; $display("FAIL basic_read: at=%0d err=%b pulses=%0d want 3/0/1", at, e, p); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_enable;
        int at, p; logic e; logic [31:0] rd;
        void'(model(0, 1, 12'd7, 32'h11223344, 4'hF, 3'b000));
        xfer(0, 1, 12'd7, 32'h11223344, 4'hF, 3'b000, 0, at, e, p, rd);
        void'(model(0, 1, 12'd7, 32'hAABBCCDD, 4'b0101, 3'b000));
        xfer(0, 1, 12'd7, 32'hAABBCCDD, 4'b0101, 3'b000, 0, at, e, p, rd);
        xfer(0, 1, 12'd7, 32'h55555555, 4'b0000, 3'b000, 0, at, e, p, rd);
        total++; if (at != 3 || e !== 1'b0 || p != 1) begin bad++; $display("FAIL sel0_ack: at=%0d err=%b pulses=%0d want 3/0/1", at, e, p); end
        xfer(0, 0, 12'd7, 32'h0, 4'hF, 3'b000, 0, at, e, p, rd);
        total++; if (rd !== 32'h11BB33DD || rd !== ref_mem[0][7]) begin bad++; $display("FAIL byte_enable: got %h want 11bb33dd", rd); end
    endtask

    task automatic test_out_of_range;
        int at, p; logic e; logic [31:0] rd;
        void'(model(0, 1, 12'd0, 32'h12345678, 4'hF, 3'b000));
        xfer(0, 1, 12'd0, 32'h12345678, 4'hF, 3'b000, 0, at, e, p, rd);
        xfer(0, 0, 12'd5, 32'h0, 4'hF, 3'b000, 0, at, e, p, rd);
        xfer(0, 0, 12'h400, 32'h0, 4'hF, 3'b000, 0, at, e, p, rd);
        total++; if (at != 3 || e !== 1'b1 || p != 1) begin bad++; $display("FAIL oor_read: at=%0d err=%b pulses=%0d want 3/1/1", at, e, p); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL oor_data_held: got %h want deadbeef", rd); end
        xfer(0, 1, 12'h400, 32'hCAFEF00D, 4'hF, 3'b000, 0, at, e, p, rd);
        total++; if (at != 3 || e !== 1'b1 || p != 1) begin bad++; $display("FAIL oor_write: at=%0d err=%b pulses=%0d want 3/1/1", at, e, p); end
        xfer(0, 0, 12'd0, 32'h0, 4'hF, 3'b000, 0, at, e, p, rd);
        total++; if (rd !== ref_mem[0][0]) begin bad++; $display("FAIL oor_no_write: mem[0]=%h want %h", rd, ref_mem[0][0]); end
    endtask

    task automatic test_abort;
        int at, p; logic e; logic [31:0] rd;
        void'(model(0, 1, 12'd9, 32'h99990000, 4'hF, 3'b000));
        xfer(0, 1, 12'd9, 32'h99990000, 4'hF, 3'b000, 0, at, e, p, rd);
        xfer(0, 1, 12'd9, 32'h0BADBAD0, 4'hF, 3'b000, 1, at, e, p, rd);
        total++; if (p != 0) begin bad++; $display("FAIL abort_resp: pulses=%0d want 0", p); end
        xfer(0, 0, 12'd9, 32'h0, 4'hF, 3'b000, 0, at, e, p, rd);
        total++; if (at != 3 || rd !== ref_mem[0][9]) begin bad++; $display("FAIL abort_nowrite: at=%0d data=%h want 3/%h", at, rd, ref_mem[0][9]); end
    endtask

    task automatic test_cti;
        int at, p; logic e; logic [31:0] rd; logic [2:0] c;
        for (int i = 0; i < 8; i++) begin
            c = 3'(i);
            xfer(0, 0, 12'd5, 32'h0, 4'hF, c, 0, at, e, p, rd);
            total++;
            if (at != 3 || p != 1 || e !== model(0, 0, 12'd5, 32'h0, 4'hF, c) || (!e && rd !== ref_mem[0][5])) begin
                bad++; $display("FAIL cti_%0d: at=%0d err=%b pulses=%0d data=%h", i, at, e, p, rd);
            end
        end
    endtask

    task automatic test_reset_mid;
        int at, p; logic e; logic [31:0] rd;
        i_we = 0; i_addr = 12'd5; i_sel = 4'hF; i_cti = 0; i_stb = 1; cyc[0] = 1;
        @(posedge i_clk); #1;
        i_reset = 1; i_stb = 0; cyc[0] = 0;
        @(posedge i_clk); #1;
        total++; if (ack[0] !== 1'b0 || err[0] !== 1'b0) begin bad++; $display("FAIL reset_mid: ack=%b err=%b want 0/0", ack[0], err[0]); end
        i_reset = 0;
        p = 0;
        repeat (5) begin @(posedge i_clk); #1; p += int'(ack[0]) + int'(err[0]); end
        total++; if (p != 0) begin bad++; $display("FAIL reset_mid_silent: pulses=%0d want 0", p); end
        xfer(0, 0, 12'd5, 32'h0, 4'hF, 3'b000, 0, at, e, p, rd);
        total++; if (at != 3 || rd !== ref_mem[0][5]) begin bad++; $display("FAIL reset_mid_after: at=%0d data=%h want 3/%h", at, rd, ref_mem[0][5]); end
    endtask

    task automatic test_random;
        int at, p; logic e, ee, we; logic [31:0] rd, d; logic [11:0] a; logic [3:0] s; logic [2:0] c;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            void'(model(0, 1, 12'(i), d, 4'hF, 3'b000));
            xfer(0, 1, 12'(i), d, 4'hF, 3'b000, 0, at, e, p, rd);
        end
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(1024, 4095)) : 12'($urandom_range(0, 15));
            we = 1'($urandom); d = $urandom; s = 4'($urandom); c = 3'($urandom);
            ee = model(0, we, a, d, s, c);
            xfer(0, we, a, d, s, c, 0, at, e, p, rd);
            total++;
            if (at != 3 || p != 1 || e !== ee || (!ee && !we && valid[0][a[9:0]] && rd !== ref_mem[0][a[9:0]])) begin
                bad++; $display("FAIL random_%0d: a=%h we=%b cti=%b at=%0d err=%b pulses=%0d data=%h want err=%b data=%h",
                                i, a, we, c, at, e, p, rd, ee, ref_mem[0][a[9:0]]);
            end
        end
    endtask

    // Four transfers at addrs 0..3 with i_stb held continuously; acks spaced WAITS+2 apart
    task automatic b2b(input int w, input logic we, input logic [31:0] base);
        int n, last, want; logic prev;
        n = 0; last = 0; prev = 0;
        i_we = we; i_addr = 0; i_data = base; i_sel = 4'hF; i_cti = 3'b010; i_stb = 1; cyc[w] = 1;
        for (int k = 1; k <= 40 && n < 4; k++) begin
            @(posedge i_clk); #1;
            total++; if (ack[w] && prev) begin bad++; $display("FAIL b2b_consecutive[%0d]: ack high twice at cycle %0d", w, k); end
            prev = ack[w];
            if (ack[w] || err[w]) begin
                want = (n == 0) ? waits_of(w) + 1 : last + waits_of(w) + 2;
                total++; if (k != want || err[w] !== 1'b0) begin bad++; $display("FAIL b2b_timing[%0d]: xfer %0d at %0d err=%b want %0d/0", w, n, k, err[w], want); end
                if (we) void'(model(w, 1, 12'(n), base + 32'(n), 4'hF, 3'b010));
                else begin
                    total++; if (rdata[w] !== ref_mem[w][n]) begin bad++; $display("FAIL b2b_data[%0d]: addr %0d got %h want %h", w, n, rdata[w], ref_mem[w][n]); end
                end
                n++; last = k; i_addr = 12'(n); i_data = base + 32'(n);
                if (n == 4) begin i_stb = 0; cyc[w] = 0; end
            end
        end
        i_stb = 0; cyc[w] = 0;
        total++; if (n != 4) begin bad++; $display("FAIL b2b_timeout[%0d]: %0d of 4 responses", w, n); end
        @(posedge i_clk); #1;
        total++; if (ack[w] && prev) begin bad++; $display("FAIL b2b_tail[%0d]: ack high twice", w); end
        @(posedge i_clk); #1;
    endtask

    task automatic test_back_to_back;
        b2b(1, 1, 32'hA0A0_0000);
        b2b(1, 0, 32'h0);
        b2b(0, 1, 32'h5000_0100);
        b2b(0, 0, 32'h0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_byte_enable;
        test_out_of_range;
        test_abort;
        test_cti;
        test_reset_mid;
        test_random;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wbc_waitmem.md
Name: wbc_waitmem

Overview:
- Wishbone B3 classic slave: a single-port on-chip RAM with a programmable number of wait states.
- Sits directly downstream of the pipelined-to-classic bridge and consumes its classic o_m* bus.
- Exercises the bridge's stb-hold and one-shot ack rules against a slow, realistic target.
- Reports out-of-range addresses and reserved cycle types with err instead of ack.

Parameters:
- AW, 12, address width in words.
- DW, 32, data width; must be a multiple of 8.
- LGMEMSZ, 10, log2 of memory depth in words; must satisfy LGMEMSZ <= AW.
- WAITS, 2, wait cycles inserted before each ack/err; range 0..15.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  reset
- i_cyc  input  1  classic bus cycle
- i_stb  input  1  strobe; held until ack/err
- i_we  input  1  1 = write
- i_addr  input  AW  word address
- i_data  input  DW  write data
- i_sel  input  DW/8  byte enables
- i_cti  input  3  cycle type indicator
- i_bte  input  2  burst type; ignored
- o_ack  output  1  transfer complete, one-cycle pulse
- o_data  output  DW  read data, valid with o_ack
- o_err  output  1  bus error, one-cycle pulse

Behaviour:
- Reset: i_reset is synchronous, active-high; clock is i_clk. On reset: state IDLE, wait counter 0, o_ack=0, o_err=0, o_data=0. Memory contents are not reset.
- Request: i_cyc && i_stb while in IDLE.
- Classification, latched at request acceptance:
  - bad_addr = (i_addr[AW-1:LGMEMSZ] != 0); never true when LGMEMSZ==AW.
  - bad_cti = i_cti in 3'b011..3'b110.
  - Classic (000), const burst (001), incr burst (010) and end-of-burst (111) are all served as single classic transfers.
- FSM:
  - IDLE: on request, load counter with WAITS. Go to WAIT if WAITS>0, else RESP.
  - WAIT: decrement the counter each cycle; when it reaches 1, go to RESP.
  - RESP: for one cycle assert o_ack (or o_err if bad_addr||bad_cti); then go to IDLE.
  - Responses are registered. With the request first visible in cycle 0, o_ack/o_err is high in cycle WAITS+1 only.
- Exclusivity: o_ack and o_err are never both high. Each is never high for two consecutive cycles.
- Back-to-back: after a response, IDLE may accept a new request in the very next cycle if i_stb is still high. That request is treated as a new transfer per B3 classic. Minimum spacing between responses is WAITS+2 cycles.
- Write:
  - Committed on the same clock edge that raises o_ack, only for the bytes with i_sel set.
  - i_sel==0 still acks and changes nothing.
  - An error transfer never writes.
- Read:
  - o_data is loaded from mem[i_addr[LGMEMSZ-1:0]] on the edge raising o_ack.
  - o_data holds its value otherwise; it is unchanged on o_err.
- Request inputs: i_we, i_addr, i_data and i_sel are sampled at the response edge. The master must hold them stable while i_stb is high.
- Abort: i_cyc low, or i_stb low, in WAIT or RESP returns the FSM to IDLE next cycle. No ack, no err, no write.
- Reset mid-transfer: FSM returns to IDLE; no response is issued.
- Wait counter: width $clog2(WAITS+1), minimum 1 bit; it never wraps.

Test Plan:
- WAITS=2: write 0xDEADBEEF to addr 5 (sel=4'hF), then read addr 5 -> o_ack high exactly in cycle 3 after each request; read o_data=0xDEADBEEF.
- Byte enables: addr 7 preloaded 0x11223344; write 0xAABBCCDD with sel=4'b0101 -> read returns 0x11BB33DD.
- Out of range (LGMEMSZ=10, AW=12): read addr 0x400 -> o_err pulse in cycle 3, o_ack=0, o_data unchanged. Write to 0x400 -> err, and mem[0] is unchanged.
- Abort: start a write to addr 9 and drop i_cyc in cycle 1 -> no ack/err ever. A subsequent read of addr 9 returns the old value.
- WAITS=0 via the bridge: pipelined master issues 4 reads at addrs 0..3 -> each classic ack comes one cycle after its stb. Bridge returns 4 acks in order with the correct data; o_ack never high on consecutive cycles.
- Reserved cti=3'b100 read -> o_err. Assert i_reset while in WAIT -> o_ack=o_err=0 and IDLE on the next cycle.
